// File: rtl/pipe_addsub_unit_if.sv
// Operand/result handshake bundle for the pipelined add/sub/compare unit.
// The unit itself connects through the slave modport; its driver uses the master modport.
interface pipe_addsub_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [1:0]      op_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] result_o;
    logic            carry_o;
    logic            ovf_o;
    logic            zero_o;
    logic            neg_o;

    modport slave (
        input  in_valid_i, a_i, b_i, op_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, carry_o, ovf_o, zero_o, neg_o
    );

    modport master (
        output in_valid_i, a_i, b_i, op_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, carry_o, ovf_o, zero_o, neg_o
    );
endinterface

// File: rtl/pipe_addsub_unit.sv
// Pipelined ADD/SUB/SLT/SLTU unit: the XLEN carry chain is cut into STAGES chunks,
// one chunk resolved per stage with the carry registered between stages.
module pipe_addsub_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    pipe_addsub_unit_if.slave bus
);
    localparam int CHUNK = XLEN / STAGES;
    localparam int LAST  = STAGES - 1;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_SLT  = 2'b10,
        OP_SLTU = 2'b11
    } op_e;

    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    endfunction

    function automatic logic signed_ovf(input logic a_msb, input logic bx_msb,
                                        input logic sum_msb);
        return (a_msb == bx_msb) && (sum_msb != a_msb);
    endfunction

    // Per-stage state; operands travel whole so the final stage still sees A/bx MSBs.
    logic [STAGES-1:0] vld_q, vld_d, vld_src, ld;
    logic [STAGES-1:0] cy_q, cy_d, cy_src;
    logic [XLEN-1:0]   a_q   [STAGES];
    logic [XLEN-1:0]   a_d   [STAGES];
    logic [XLEN-1:0]   a_src [STAGES];
    logic [XLEN-1:0]   bx_q  [STAGES];
    logic [XLEN-1:0]   bx_d  [STAGES];
    logic [XLEN-1:0]   bx_src[STAGES];
    logic [XLEN-1:0]   sum_q [STAGES];
    logic [XLEN-1:0]   sum_d [STAGES];
    logic [XLEN-1:0]   sum_src[STAGES];
    op_e               op_q  [STAGES];
    op_e               op_d  [STAGES];
    op_e               op_src[STAGES];
    logic [CHUNK:0]    csum  [STAGES];
    logic              in_ready;

    // Stage inputs: stage 0 conditions the incoming operands, later stages take the previous register.
    always_comb begin
        a_src[0]   = bus.a_i;
        bx_src[0]  = (op_e'(bus.op_i) == OP_ADD) ? bus.b_i : ~bus.b_i;
        sum_src[0] = '0;
        cy_src[0]  = (op_e'(bus.op_i) != OP_ADD);
        op_src[0]  = op_e'(bus.op_i);
        for (int k = 1; k < STAGES; k++) begin
            a_src[k]   = a_q[k-1];
            bx_src[k]  = bx_q[k-1];
            sum_src[k] = sum_q[k-1];
            cy_src[k]  = cy_q[k-1];
            op_src[k]  = op_q[k-1];
        end
    end

    // Load enables ripple back from the output: a stage loads when empty or when its successor loads.
    always_comb begin
        ld[LAST] = !vld_q[LAST] || bus.out_ready_i;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ld[k] = !vld_q[k] || ld[k+1];
        end
        in_ready   = ld[0] && !flush_i;
        vld_src[0] = bus.in_valid_i && in_ready;
        for (int k = 1; k < STAGES; k++) begin
            vld_src[k] = vld_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            csum[k]  = chunk_add(a_src[k][k*CHUNK +: CHUNK], bx_src[k][k*CHUNK +: CHUNK], cy_src[k]);
            a_d[k]   = a_q[k];
            bx_d[k]  = bx_q[k];
            sum_d[k] = sum_q[k];
            cy_d[k]  = cy_q[k];
            op_d[k]  = op_q[k];
            if (ld[k]) begin
                a_d[k]   = a_src[k];
                bx_d[k]  = bx_src[k];
                sum_d[k] = sum_src[k];
                sum_d[k][k*CHUNK +: CHUNK] = csum[k][CHUNK-1:0];
                cy_d[k]  = csum[k][CHUNK];
                op_d[k]  = op_src[k];
            end
            vld_d[k] = flush_i ? 1'b0 : (ld[k] ? vld_src[k] : vld_q[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        cy_q <= cy_d;
        for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            bx_q[k]  <= bx_d[k];
            sum_q[k] <= sum_d[k];
            op_q[k]  <= op_d[k];
        end
    end

    // Final stage: flags from the completed sum; everything reads 0 while no result is held.
    logic [XLEN-1:0] sum_fin;
    logic [XLEN-1:0] res_fin;
    logic            ovf_fin;
    logic            neg_fin;
    logic            zero_fin;
    logic            carry_fin;

    always_comb begin
        sum_fin   = sum_q[LAST];
        carry_fin = cy_q[LAST];
        neg_fin   = sum_fin[XLEN-1];
        zero_fin  = (sum_fin == '0);
        ovf_fin   = signed_ovf(a_q[LAST][XLEN-1], bx_q[LAST][XLEN-1], sum_fin[XLEN-1]);
        case (op_q[LAST])
            OP_SLT:  res_fin = {{(XLEN-1){1'b0}}, neg_fin ^ ovf_fin};
            OP_SLTU: res_fin = {{(XLEN-1){1'b0}}, ~carry_fin};
            default: res_fin = sum_fin;
        endcase
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = vld_q[LAST];
    assign bus.result_o    = vld_q[LAST] ? res_fin : '0;
    assign bus.carry_o     = vld_q[LAST] && carry_fin;
    assign bus.ovf_o       = vld_q[LAST] && ovf_fin;
    assign bus.zero_o      = vld_q[LAST] && zero_fin;
    assign bus.neg_o       = vld_q[LAST] && neg_fin;
endmodule

// File: doc/pipe_addsub_unit.md
Name: pipe_addsub_unit

Overview:
- Parametrised, pipelined integer add/sub/compare unit for the RISC-V execute path.
- Splits the XLEN-bit carry chain into STAGES equal chunks, one chunk per pipeline stage, with a carry register between stages.
- Supports ADD, SUB, SLT and SLTU, and produces NZCV flags for branch compare.
- Uses valid/ready handshakes on both sides, with per-stage stall and a synchronous flush.

Parameters:
XLEN, 32, operand/result width in bits
STAGES, 2, pipeline stages = latency in cycles; legal values 1..XLEN with XLEN % STAGES == 0; CHUNK = XLEN/STAGES

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  synchronous active-low reset
flush_i  input  1  drop all in-flight operations
in_valid_i  input  1  operand beat valid
in_ready_o  output  1  unit accepts beat this cycle
a_i  input  XLEN  operand A
b_i  input  XLEN  operand B
op_i  input  2  00 ADD, 01 SUB, 10 SLT, 11 SLTU
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
result_o  output  XLEN  ADD/SUB: sum; SLT/SLTU: zero-extended compare bit
carry_o  output  1  carry-out of MSB (SUB/SLT/SLTU: 1 = no borrow)
ovf_o  output  1  signed overflow
zero_o  output  1  arithmetic sum == 0
neg_o  output  1  arithmetic sum MSB

Behaviour:
- Reset (rst_ni low at a clock edge): all stage valids clear; out_valid_o = 0; result_o and all flags = 0. Data registers need not be reset, but the outputs must read 0 while invalid after reset.
- Reset mid-operation discards every in-flight beat. No partial result is ever emitted.
- Operand conditioning at capture:
  - bx = B when op = ADD; bx = ~B for SUB, SLT and SLTU.
  - Carry-in to chunk 0 = 1 for SUB/SLT/SLTU, 0 for ADD.
- Stage k (k = 0..STAGES-1):
  - Adds chunk k of A and bx plus the carry from stage k-1 (stage 0 uses the carry-in).
  - Registers the CHUNK sum bits and the carry.
  - Carries forward the already-summed lower chunks, the still-unsummed upper operand chunks, and op.
- Flags are computed combinationally from the final-stage registers:
  - carry_o = final carry.
  - ovf_o = (A[MSB] == bx[MSB]) && (sum[MSB] != A[MSB]).
  - neg_o = sum[MSB].
  - zero_o = (sum == 0).
  - Flags are valid for every op.
- result_o:
  - ADD/SUB: sum mod 2^XLEN.
  - SLT: {0, neg_o ^ ovf_o}.
  - SLTU: {0, ~carry_o}.
- Latency: a beat accepted at edge t is presented with out_valid_o = 1 after edge t+STAGES-1 (registered output of the last stage), given no backpressure.
- Throughput: one beat per cycle.
- Stall rules:
  - The last stage may load when it is empty or out_ready_i = 1.
  - Stage k may load when stage k is empty or stage k+1 may load.
  - in_ready_o = stage 0 may load. It may depend combinationally on out_ready_i.
  - A held stage keeps all of its data stable.
  - out_valid_o and result_o/flags stay stable while out_valid_o && !out_ready_i.
- Handshake:
  - A beat is accepted only when in_valid_i && in_ready_o.
  - A result retires when out_valid_o && out_ready_i.
  - A simultaneous retire and accept in a full pipe is legal and loses nothing.
- flush_i:
  - Clears all stage valids at the edge; out_valid_o = 0 the next cycle.
  - A beat offered in the same cycle as flush_i is dropped. in_ready_o is forced 0 during flush_i.
  - Reset has priority over flush.
- Wrap-around: ADD of 0xFFFFFFFF + 1 yields 0 with carry 1. No saturation.
- STAGES = 1 degenerates to a single registered adder with latency 1.

Test Plan:
- ADD, XLEN = 32, STAGES = 2: 0x7FFFFFFF + 0x00000001 -> result 0x80000000, ovf 1, neg 1, carry 0, zero 0, out_valid exactly 2 cycles after accept.
- SUB/SLT/SLTU with A = 0x00000001, B = 0xFFFFFFFF:
  - SUB -> 0x00000002, carry 0.
  - SLT -> 0 (1 > -1).
  - SLTU -> 1 (borrow).
  - SUB with A = B = 0x1234 -> zero 1, carry 1.
- Carry across a chunk boundary: ADD 0x0000FFFF + 0x00000001 with STAGES = 2 and STAGES = 4 -> 0x00010000. ADD 0xFFFFFFFF + 1 -> 0, carry 1, zero 1.
- Backpressure:
  - Stream 6 back-to-back beats while holding out_ready_i = 0 for 3 cycles mid-stream.
  - Expect in_ready_o to drop once the pipe is full, and outputs to stay stable while stalled.
  - All 6 results must appear in order with no loss or duplication.
- Flush: with 2 beats in flight plus one offered, assert flush_i for 1 cycle -> no out_valid_o for any of the 3. A beat accepted the cycle after flush completes normally.
- Reset mid-stream: drop rst_ni for 1 cycle with the pipe full -> out_valid_o = 0 and outputs = 0 the next cycle, with no stale results afterward.
